// File: rtl/mux_bus_master.sv
// Multiplexed address/data bus master: one request at a time, serialised into BUS_W beats.
// Optional external wait-state extension is enabled by defining MUX_BUS_WAIT_EN.
module mux_bus_master #(
  parameter int BUS_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              pause,
  input  logic [BUS_W-1:0]  bus_in,
  output logic [BUS_W-1:0]  bus_out,
  output logic [BUS_W-1:0]  bus_oe,
  output logic              ale,
  output logic              en,
  output logic              rw,
  input  logic              bus_wait,
  output logic              busy
);

  localparam int NA = ADDR_W / BUS_W;
  localparam int ND = DATA_W / BUS_W;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              state_q;
  logic [7:0]          beat_q;
  logic [3:0]          wait_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_sh_q;
  logic [DATA_W-1:0]   wd_sh_q;
  logic [DATA_W-1:0]   rd_sh_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [BUS_W-1:0]    bus_out_q;
  logic [BUS_W-1:0]    bus_oe_q;
  logic                ale_q;
  logic                en_q;
  logic                rw_q;
  logic                rsp_valid_q;
  logic                busy_q;

  logic [DATA_W+BUS_W-1:0] rd_cat_d;
  logic [DATA_W-1:0]       rd_shift_d;
  logic                    beat_done_d;

  assign req_ready = (state_q == S_IDLE) && !pause;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign ale       = ale_q;
  assign en        = en_q;
  assign rw        = rw_q;
  assign busy      = busy_q;

`ifndef MUX_BUS_WAIT_EN
  logic unused_bus_wait;
  assign unused_bus_wait = bus_wait;
`endif

  // Read shift-in value and end-of-beat detection (the last cycle may be stretched by bus_wait)
  always_comb begin
    rd_cat_d   = {rd_sh_q, bus_in};
    rd_shift_d = rd_cat_d[DATA_W-1:0];
`ifdef MUX_BUS_WAIT_EN
    beat_done_d = (wait_q == 4'(WAIT_CYCLES)) && !bus_wait;
`else
    beat_done_d = (wait_q == 4'(WAIT_CYCLES));
`endif
  end

  // Bus FSM with registered pin outputs; pause freezes every register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= 8'd0;
      wait_q      <= 4'd0;
      we_q        <= 1'b0;
      addr_sh_q   <= '0;
      wd_sh_q     <= '0;
      rd_sh_q     <= '0;
      rsp_rdata_q <= '0;
      bus_out_q   <= '0;
      bus_oe_q    <= '0;
      ale_q       <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (!pause) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q   <= S_ADDR;
            beat_q    <= 8'd0;
            we_q      <= req_we;
            addr_sh_q <= req_addr << BUS_W;
            wd_sh_q   <= req_wdata;
            bus_out_q <= req_addr[ADDR_W-1 -: BUS_W];
            bus_oe_q  <= {BUS_W{1'b1}};
            ale_q     <= 1'b1;
            rw_q      <= !req_we;
            busy_q    <= 1'b1;
          end
        end
        S_ADDR: begin
          if (beat_q == 8'(NA-1)) begin
            state_q <= S_DATA;
            beat_q  <= 8'd0;
            wait_q  <= 4'd0;
            ale_q   <= 1'b0;
            en_q    <= 1'b1;
            if (we_q) begin
              bus_out_q <= wd_sh_q[DATA_W-1 -: BUS_W];
              wd_sh_q   <= wd_sh_q << BUS_W;
            end else begin
              bus_out_q <= '0;
              bus_oe_q  <= '0;
            end
          end else begin
            beat_q    <= beat_q + 8'd1;
            bus_out_q <= addr_sh_q[ADDR_W-1 -: BUS_W];
            addr_sh_q <= addr_sh_q << BUS_W;
          end
        end
        S_DATA: begin
          if (beat_done_d) begin
            if (!we_q) begin
              rd_sh_q <= rd_shift_d;
            end
            // Final beat: the response cycle carries the freshly assembled read word
            if (beat_q == 8'(ND-1)) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              en_q        <= 1'b0;
              rw_q        <= 1'b0;
              bus_out_q   <= '0;
              bus_oe_q    <= '0;
              if (!we_q) begin
                rsp_rdata_q <= rd_shift_d;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
              wait_q <= 4'd0;
              if (we_q) begin
                bus_out_q <= wd_sh_q[DATA_W-1 -: BUS_W];
                wd_sh_q   <= wd_sh_q << BUS_W;
              end
            end
          end else if (wait_q != 4'(WAIT_CYCLES)) begin
            wait_q <= wait_q + 4'd1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          ale_q       <= 1'b0;
          en_q        <= 1'b0;
          rw_q        <= 1'b0;
          bus_out_q   <= '0;
          bus_oe_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_bus_master.sv
// Directed bench for mux_bus_master: default build plus a narrow-address / wide-data instance.
module tb_mux_bus_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we, pause, bus_wait;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  bus_in;
    logic        req_ready, rsp_valid, ale, en, rw, busy;
    logic [15:0] rsp_rdata;
    logic [7:0]  bus_out, bus_oe;

    logic        req_valid2, req_we2, pause2, bus_wait2;
    logic [7:0]  req_addr2;
    logic [31:0] req_wdata2;
    logic [7:0]  bus_in2;
    logic        req_ready2, rsp_valid2, ale2, en2, rw2, busy2;
    logic [31:0] rsp_rdata2;
    logic [7:0]  bus_out2, bus_oe2;

    int vecs = 0;
    int errs = 0;

    wire [21:0] obs = {req_ready, ale, en, rw, busy, rsp_valid, bus_oe, bus_out};

    mux_bus_master dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .pause(pause),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .ale(ale), .en(en),
        .rw(rw), .bus_wait(bus_wait), .busy(busy)
    );

    mux_bus_master #(.BUS_W(8), .ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .pause(pause2),
        .bus_in(bus_in2), .bus_out(bus_out2), .bus_oe(bus_oe2), .ale(ale2), .en(en2),
        .rw(rw2), .bus_wait(bus_wait2), .busy(busy2)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [21:0] row(input logic rdy, input logic a, input logic e,
                                        input logic r, input logic b, input logic v,
                                        input logic [7:0] oe, input logic [7:0] o);
        return {rdy, a, e, r, b, v, oe, o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vecs++;
        if (obs !== row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00)) begin
            errs++;
            $display("FAIL reset_pins: got %h expected %h", obs, row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
        end
        vecs++;
        if (rsp_rdata !== 16'h0000 || rsp_rdata2 !== 32'h0) begin
            errs++;
            $display("FAIL reset_rdata: got %h/%h expected 0000/00000000", rsp_rdata, rsp_rdata2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        logic [21:0] ex [0:7];
        logic [7:0]  bin [0:7];
        ex[0] = row(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h12);
        ex[1] = row(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hA4);
        for (int k = 2; k < 6; k++) ex[k] = row(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        ex[6] = row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        ex[7] = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        bin = '{8'h00, 8'h00, 8'hFF, 8'h5A, 8'h00, 8'hC3, 8'h00, 8'h00};
        issue(1'b0, 16'h12A4, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            bus_in = bin[k];
            vecs++;
            if (obs !== ex[k]) begin
                errs++;
                $display("FAIL read_pins k=%0d: got %h expected %h", k, obs, ex[k]);
            end
            if (k == 6 || k == 7) begin
                vecs++;
                if (rsp_rdata !== 16'h5AC3) begin
                    errs++;
                    $display("FAIL read_rdata k=%0d: got %h expected 5ac3", k, rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_write();
        logic [21:0] ex [0:7];
        ex[0] = row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
        ex[1] = row(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h10);
        ex[2] = row(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hBE);
        ex[3] = ex[2];
        ex[4] = row(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hEF);
        ex[5] = ex[4];
        ex[6] = row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        ex[7] = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        bus_in = 8'h77;
        issue(1'b1, 16'h0010, 16'hBEEF);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            vecs++;
            if (obs !== ex[k]) begin
                errs++;
                $display("FAIL write_pins k=%0d: got %h expected %h", k, obs, ex[k]);
            end
        end
        vecs++;
        if (rsp_rdata !== 16'h5AC3) begin
            errs++;
            $display("FAIL write_keeps_rdata: got %h expected 5ac3", rsp_rdata);
        end
    endtask

    task automatic test_pause();
        logic [21:0] ex [0:10];
        logic [7:0]  bin [0:10];
        ex[0] = row(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C);
        ex[1] = row(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
        for (int k = 2; k < 9; k++) ex[k] = row(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        ex[9]  = row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        ex[10] = row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        bin = '{8'h00, 8'h00, 8'h00, 8'h77, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'h19, 8'h00, 8'h00};
        issue(1'b0, 16'h3C00, 16'h0000);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) step();
            bus_in = bin[k];
            pause  = (k >= 4 && k <= 6);
            vecs++;
            if (obs !== ex[k]) begin
                errs++;
                $display("FAIL pause_pins k=%0d: got %h expected %h", k, obs, ex[k]);
            end
        end
        vecs++;
        if (rsp_rdata !== 16'h7719) begin
            errs++;
            $display("FAIL pause_rdata: got %h expected 7719", rsp_rdata);
        end
    endtask

    task automatic test_pause_idle();
        pause     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h1111;
        #1;
        vecs++;
        if (req_ready !== 1'b0) begin
            errs++;
            $display("FAIL pause_idle_ready: got %b expected 0", req_ready);
        end
        step();
        vecs++;
        if ({busy, ale} !== 2'b00) begin
            errs++;
            $display("FAIL pause_idle_accept: busy/ale got %b expected 00", {busy, ale});
        end
        req_valid = 1'b0;
        pause     = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bus_in    = 8'h66;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h4321;
        req_wdata = 16'h0F0F;
        step();
        req_we   = 1'b0;
        req_addr = 16'h9876;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step();
            if (k == 6) begin
                vecs++;
                if (req_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_not_ready: got %b expected 0", req_ready);
                end
            end
            if (k == 7) begin
                vecs++;
                if ({req_ready, busy} !== 2'b10) begin
                    errs++;
                    $display("FAIL b2b_idle_gap: ready/busy got %b expected 10", {req_ready, busy});
                end
            end
            if (k == 8) begin
                req_valid = 1'b0;
                vecs++;
                if ({ale, rw, busy, bus_out} !== {3'b111, 8'h98}) begin
                    errs++;
                    $display("FAIL b2b_second_accept: got %h expected %h", {ale, rw, busy, bus_out}, {3'b111, 8'h98});
                end
            end
            if (k == 13 || k == 14) begin
                vecs++;
                if (rsp_valid !== (k == 14)) begin
                    errs++;
                    $display("FAIL b2b_rsp k=%0d: got %b expected %b", k, rsp_valid, (k == 14));
                end
            end
        end
        vecs++;
        if (rsp_rdata !== 16'h6666) begin
            errs++;
            $display("FAIL b2b_rdata: got %h expected 6666", rsp_rdata);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 16'h0010, 16'h1234);
        vecs++;
        if (ale !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid_started: ale got %b expected 1", ale);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (obs !== row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00) || rsp_rdata !== 16'h0000) begin
            errs++;
            $display("FAIL rst_mid_async: got %h/%h expected 200000/0000", obs, rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            vecs++;
            if (obs !== row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00)) begin
                errs++;
                $display("FAIL rst_mid_idle k=%0d: got %h expected 200000", k, obs);
            end
        end
        issue(1'b0, 16'hA55A, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            bus_in = (k == 3) ? 8'h01 : ((k == 5) ? 8'h80 : 8'h00);
            vecs++;
            if (rsp_valid !== (k == 6)) begin
                errs++;
                $display("FAIL rst_mid_rsp k=%0d: got %b expected %b", k, rsp_valid, (k == 6));
            end
        end
        vecs++;
        if (rsp_rdata !== 16'h0180) begin
            errs++;
            $display("FAIL rst_mid_rdata: got %h expected 0180", rsp_rdata);
        end
    endtask

    task automatic test_wide();
        logic [7:0] bin [0:5];
        bin = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        req_valid2 = 1'b1;
        req_we2    = 1'b0;
        req_addr2  = 8'h5E;
        step();
        req_valid2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            bus_in2 = bin[k];
            vecs++;
            if (k == 0 && {ale2, en2, bus_oe2, bus_out2} !== {2'b10, 8'hFF, 8'h5E}) begin
                errs++;
                $display("FAIL wide_addr: got %h expected %h", {ale2, en2, bus_oe2, bus_out2}, {2'b10, 8'hFF, 8'h5E});
            end else if (k >= 1 && k <= 4 && {ale2, en2, bus_oe2, rsp_valid2} !== {2'b01, 8'h00, 1'b0}) begin
                errs++;
                $display("FAIL wide_rdbeat k=%0d: got %h expected %h", k, {ale2, en2, bus_oe2, rsp_valid2}, {2'b01, 8'h00, 1'b0});
            end else if (k == 5 && {rsp_valid2, rsp_rdata2} !== {1'b1, 32'hDEADBEEF}) begin
                errs++;
                $display("FAIL wide_rdata: got %h expected %h", {rsp_valid2, rsp_rdata2}, {1'b1, 32'hDEADBEEF});
            end
        end
        step();
        req_valid2 = 1'b1;
        req_we2    = 1'b1;
        req_addr2  = 8'hA0;
        req_wdata2 = 32'h01020304;
        step();
        req_valid2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            vecs++;
            if (k >= 1 && k <= 4 && {en2, bus_oe2, bus_out2} !== {1'b1, 8'hFF, 8'(k)}) begin
                errs++;
                $display("FAIL wide_wrbeat k=%0d: got %h expected %h", k, {en2, bus_oe2, bus_out2}, {1'b1, 8'hFF, 8'(k)});
            end else if (k == 5 && {rsp_valid2, rsp_rdata2} !== {1'b1, 32'hDEADBEEF}) begin
                errs++;
                $display("FAIL wide_wr_rsp: got %h expected %h", {rsp_valid2, rsp_rdata2}, {1'b1, 32'hDEADBEEF});
            end else if (k == 0 && {ale2, bus_out2} !== {1'b1, 8'hA0}) begin
                errs++;
                $display("FAIL wide_wr_addr: got %h expected %h", {ale2, bus_out2}, {1'b1, 8'hA0});
            end
        end
        step();
    endtask

    task automatic test_wait();
        logic [7:0]  bin [0:8];
        int          rsp_k;
        logic [15:0] exp_rd;
`ifdef MUX_BUS_WAIT_EN
        rsp_k  = 8;
        exp_rd = 16'h4299;
`else
        rsp_k  = 6;
        exp_rd = 16'hEE42;
`endif
        bin = '{8'h00, 8'h00, 8'hEE, 8'hEE, 8'hEE, 8'h42, 8'h00, 8'h99, 8'h00};
        issue(1'b0, 16'h0C0C, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step();
            bus_in   = bin[k];
            bus_wait = (k == 3 || k == 4);
            vecs++;
            if (en !== (k >= 2 && k < rsp_k)) begin
                errs++;
                $display("FAIL wait_en k=%0d: got %b expected %b", k, en, (k >= 2 && k < rsp_k));
            end
            vecs++;
            if (rsp_valid !== (k == rsp_k)) begin
                errs++;
                $display("FAIL wait_rsp k=%0d: got %b expected %b", k, rsp_valid, (k == rsp_k));
            end
        end
        vecs++;
        if (rsp_rdata !== exp_rd) begin
            errs++;
            $display("FAIL wait_rdata: got %h expected %h", rsp_rdata, exp_rd);
        end
    endtask

    // Test sequence and summary
    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0; req_we  = 1'b0; req_addr  = 16'h0; req_wdata  = 16'h0;
        pause      = 1'b0; bus_wait = 1'b0; bus_in = 8'h00;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h0;  req_wdata2 = 32'h0;
        pause2     = 1'b0; bus_wait2 = 1'b0; bus_in2 = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_pause();
        test_pause_idle();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        test_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mux_bus_master.md
# mux_bus_master

Parametrised master for the external multiplexed address/data bus (ALE / EN / RW, shared bidirectional pins with per-bit output enable). It accepts one read or write request at a time from the core over a valid/ready port. It serialises the address and data into BUS_W-bit beats with programmable wait states and returns read data with a one-cycle response pulse. It sits between the core and the chip-level IO pins, replacing the fixed 8-bit single-beat bus logic.

## Interface
- BUS_W, 8: external bus width; all bus pin vectors are BUS_W bits.
- ADDR_W, 16: request address width; integer multiple of BUS_W. NA = ADDR_W/BUS_W address beats.
- DATA_W, 16: data width; integer multiple of BUS_W. ND = DATA_W/BUS_W data beats.
- WAIT_CYCLES, 1: extra cycles per data beat, range 0..15. Beat length is WAIT_CYCLES+1.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  combinational, equal to (state==IDLE) & ~pause.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes).
- rsp_rdata  out  DATA_W  assembled read data; held until the next read completes.
- pause  in  1  freezes the FSM and all registered outputs while high.
- bus_in  in  BUS_W  pad input.
- bus_out  out  BUS_W  pad output data.
- bus_oe  out  BUS_W  pad output enable, 1 = drive, all bits equal.
- ale  out  1  address latch enable.
- en  out  1  data strobe.
- rw  out  1  1 = read, 0 = write; valid from ADDR through DATA.
- bus_wait  in  1  external wait request; only used with MUX_BUS_WAIT_EN.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: accepts on req_valid & req_ready, latches we/addr/wdata, then goes to ADDR.
  - ADDR: NA cycles. ale=1, bus_oe all ones, bus_out = address beat, MSB beat first.
  - DATA: ND beats of WAIT_CYCLES+1 cycles each, en=1 throughout.
    - Write: bus_oe all ones, bus_out = data beat, MSB first.
    - Read: bus_oe=0, bus_in sampled on the last cycle of each beat and shifted in MSB-first.
  - RESP: one cycle with rsp_valid=1. For reads, rsp_rdata is updated on entry to RESP. Then IDLE.
- IDLE outputs: ale=en=rw=0, bus_out=0, bus_oe=0, busy=0.
- Reset value of every registered output (bus_out, bus_oe, ale, en, rw, rsp_valid, rsp_rdata, busy) is 0. FSM resets to IDLE.
- Reset mid-transaction returns immediately to IDLE with the reset values. No rsp_valid is issued and the request is dropped.
- pause=1 holds the state, the beat and wait counters, and all registered outputs. It blocks acceptance in IDLE. Resume continues exactly where it stopped, with no beat lost or repeated.
- pause and req_valid high in the same cycle: no accept.
- Write transactions leave rsp_rdata unchanged.

## Timing
- Accept edge E0. ADDR occupies the cycles after edges E0..E0+NA-1. DATA occupies the next ND*(WAIT_CYCLES+1) cycles. RESP is the cycle after edge E0+NA+ND*(WAIT_CYCLES+1).
- With defaults: ADDR is 2 cycles and DATA is 4 cycles, so rsp_valid is high after edge E0+6. req_ready returns high after edge E0+7.
- Back-to-back requests: the next accept happens at the earliest in the first IDLE cycle. There is a minimum of one idle cycle between transactions.
- Each pause-high cycle adds exactly one cycle to the latency.

## Configuration
- MUX_BUS_WAIT_EN defined:
  - bus_wait=1 on the last cycle of a data beat extends that beat by one cycle. This repeats while bus_wait stays high.
  - Sampling of read data moves to the final, extended cycle.
- Not defined: bus_wait is ignored and beat length is fixed at WAIT_CYCLES+1.

## Test plan
- Read, defaults, addr=0x12A4, bus_in=0x5A on beat 0 and 0xC3 on beat 1 -> ale high for 2 cycles with bus_out 0x12 then 0xA4, rw=1, bus_oe=0 in DATA, rsp_valid after E0+6, rsp_rdata=0x5AC3.
- Write, addr=0x0010, wdata=0xBEEF -> bus_out 0x00, 0x10, then 0xBE for 2 cycles and 0xEF for 2 cycles, bus_oe=0xFF throughout, rw=0, rsp_valid pulse, rsp_rdata unchanged.
- pause high for 3 cycles during the second DATA beat of a read -> outputs frozen, rsp_valid after E0+9, data correct.
- rst_n low during ADDR of a write -> all outputs 0 asynchronously, no rsp_valid; a new read afterwards completes normally.
- WAIT_CYCLES=0, BUS_W=8, ADDR_W=8, DATA_W=32 -> 1 ADDR cycle, 4 single-cycle data beats, rsp_valid after E0+5.
- MUX_BUS_WAIT_EN defined, bus_wait high for 2 cycles at the end of read beat 0 -> beat 0 lasts 4 cycles, sample taken on its final cycle, rsp_valid after E0+8.
